// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall encodings, stage indices and controller state codes
package pipe_ctrl_pkg;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [1:0] CTRL_RUN         = 2'd0;
  localparam logic [1:0] CTRL_TRAP_FLUSH  = 2'd1;
  localparam logic [1:0] CTRL_TRAP_REFILL = 2'd2;
endpackage

// File: rtl/pipe_ctrl_stall_enc.sv
// pipe_stall_enc: priority encoder mem>ex>id>if turning 4 stall requests into a 6-bit stall vector
module pipe_stall_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if,
  input  logic       req_id,
  input  logic       req_ex,
  input  logic       req_mem,
  output logic [5:0] stalled
);
  always_comb
    stalled = req_mem ? STALL_MEM :
              req_ex  ? STALL_EX  :
              req_id  ? STALL_ID  :
              req_if  ? STALL_IF  : STALL_NONE;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with trap-entry FSM, refill guard, stall watchdog and stall counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REFILL_CYCLES = 2,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if_i,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic             ex_branch_flag_i,
  input  logic [31:0]      ex_branch_addr_i,
  input  logic             trap_req_i,
  input  logic [31:0]      trap_vec_i,
  output logic [5:0]       stalled_o,
  output logic             flush_o,
  output logic             pc_sel_o,
  output logic [31:0]      new_pc_o,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int RW = $clog2(REFILL_CYCLES + 1);
  localparam int WW = $clog2(STALL_TIMEOUT + 1);
  if (REFILL_CYCLES < 1) begin : g_bad_refill
    $error("pipe_ctrl: REFILL_CYCLES must be at least 1");
  end
  if (STALL_TIMEOUT < 1) begin : g_bad_timeout
    $error("pipe_ctrl: STALL_TIMEOUT must be at least 1");
  end
  logic [1:0]    state, state_n;
  logic [RW-1:0] refill_cnt;
  logic [WW-1:0] wd_cnt;
  logic [31:0]   vec_q;
  logic [5:0]    enc, stalled;
  logic          run, tf, rf, take_trap, take_br, dec;
  pipe_stall_enc u_enc (
    .req_if  (stallreq_if_i),
    .req_id  (stallreq_id_i),
    .req_ex  (stallreq_ex_i),
    .req_mem (stallreq_mem_i),
    .stalled (enc)
  );
  always_comb begin
    run       = state == CTRL_RUN;
    tf        = state == CTRL_TRAP_FLUSH;
    rf        = state == CTRL_TRAP_REFILL;
    take_trap = run & trap_req_i & ~stallreq_mem_i;
    take_br   = run & ~take_trap & ex_branch_flag_i & (enc[STAGE_EX] == NO_STOP);
    stalled   = tf ? STALL_NONE : enc;
    dec       = rf & (stalled[STAGE_IF] == NO_STOP);
    // unreachable encodings fall back to RUN
    state_n   = take_trap ? CTRL_TRAP_FLUSH :
                tf ? CTRL_TRAP_REFILL :
                (rf & ~(dec & refill_cnt == RW'(1))) ? CTRL_TRAP_REFILL : CTRL_RUN;
    stalled_o = rst ? stalled : STALL_NONE;
    flush_o   = rst & (tf | take_br);
    pc_sel_o  = rst & (tf | take_br);
    new_pc_o  = !rst ? 32'd0 : tf ? vec_q : take_br ? ex_branch_addr_i : 32'd0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= CTRL_RUN;
      refill_cnt      <= '0;
      vec_q           <= '0;
      wd_cnt          <= '0;
      stall_timeout_o <= 1'b0;
      stall_cnt_o     <= '0;
    end else begin
      state           <= state_n;
      vec_q           <= take_trap ? trap_vec_i : vec_q;
      refill_cnt      <= tf ? RW'(REFILL_CYCLES) : dec ? refill_cnt - RW'(1) : refill_cnt;
      wd_cnt          <= stalled[STAGE_PC] != STOP ? '0 :
                         wd_cnt == WW'(STALL_TIMEOUT) ? wd_cnt : wd_cnt + WW'(1);
      stall_timeout_o <= stall_timeout_o | (stalled[STAGE_PC] == STOP && wd_cnt >= WW'(STALL_TIMEOUT - 1));
      stall_cnt_o     <= stall_cnt_o + CNT_W'(|stalled);
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed check of pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
  localparam int REFILL = 2;
  localparam int TO     = 1024;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ri = 0, rd = 0, re = 0, rm = 0, bf = 0, tr = 0;
  logic [31:0] ba = 0, tv = 0;
  logic [5:0]  stalled_o;
  logic        flush_o, pc_sel_o, stall_timeout_o;
  logic [31:0] new_pc_o, stall_cnt_o;
  int          n_cmp = 0, n_bad = 0;
  int          m_mode = 0, m_rem = 0, m_wd = 0;
  logic [31:0] m_vec = 0, m_cnt = 0;
  logic        m_to = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.REFILL_CYCLES(REFILL), .STALL_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(ri), .stallreq_id_i(rd), .stallreq_ex_i(re), .stallreq_mem_i(rm),
    .ex_branch_flag_i(bf), .ex_branch_addr_i(ba), .trap_req_i(tr), .trap_vec_i(tv),
    .stalled_o(stalled_o), .flush_o(flush_o), .pc_sel_o(pc_sel_o), .new_pc_o(new_pc_o),
    .stall_timeout_o(stall_timeout_o), .stall_cnt_o(stall_cnt_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_wd = 0; m_vec = 0; m_cnt = 0; m_to = 0;
  endtask
  // called at a negedge with inputs applied; checks this cycle then advances model and clock
  task automatic step();
    int n;
    logic [5:0] st;
    logic redirect, trap;
    logic [31:0] pc;
    #1;
    n = rm ? 5 : re ? 4 : rd ? 3 : ri ? 2 : 0;
    st = 6'((1 << n) - 1);
    redirect = 0; trap = 0; pc = 0;
    if (m_mode == 1) begin
      st = 0; redirect = 1; pc = m_vec;
    end else if (m_mode == 0) begin
      if (tr && !rm) trap = 1;
      else if (bf && n < 4) begin redirect = 1; pc = ba; end
    end
    chk("stalled", 64'(stalled_o), 64'(st));
    chk("flush", 64'(flush_o), 64'(redirect));
    chk("pc_sel", 64'(pc_sel_o), 64'(redirect));
    chk("new_pc", 64'(new_pc_o), 64'(pc));
    chk("timeout", 64'(stall_timeout_o), 64'(m_to));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
    if (m_mode == 0 && trap) begin m_vec = tv; m_mode = 1; end
    else if (m_mode == 1) begin m_rem = REFILL; m_mode = 2; end
    else if (m_mode == 2 && st[1] == 1'b0) begin
      m_rem--;
      if (m_rem == 0) m_mode = 0;
    end
    if (st != 0) begin
      m_wd = (m_wd + 1 > TO) ? TO : m_wd + 1;
      if (m_wd == TO) m_to = 1;
      m_cnt++;
    end else m_wd = 0;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drv(input logic i_, d_, e_, m_, b_, input logic [31:0] a_, input logic t_, input logic [31:0] v_);
    ri = i_; rd = d_; re = e_; rm = m_; bf = b_; ba = a_; tr = t_; tv = v_;
    step();
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #1;
    chk("rst_stalled", 64'(stalled_o), 0);
    chk("rst_flush", 64'(flush_o), 0);
    chk("rst_cnt", 64'(stall_cnt_o), 0);
    @(negedge clk);
    rst = 1;
    idle(); idle();
    repeat (3) drv(0, 0, 1, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 32'h8000_0040, 0, 0);
    repeat (2) drv(0, 0, 1, 0, 1, 32'h8000_0040, 0, 0);
    drv(0, 0, 0, 0, 1, 32'h8000_0040, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 1, 32'h200);
    drv(0, 0, 0, 0, 1, 32'h8000_0040, 1, 32'h100);
    drv(1, 0, 1, 0, 1, 32'h8000_0080, 1, 32'h300);
    drv(0, 0, 0, 0, 1, 32'h8000_0080, 1, 32'h300);
    drv(1, 0, 0, 0, 1, 32'h8000_0080, 0, 0);
    drv(0, 0, 0, 0, 1, 32'h8000_0080, 1, 32'h300);
    drv(0, 0, 0, 0, 1, 32'h8000_00c0, 0, 0);
    idle();
    drv(0, 0, 0, 0, 0, 0, 1, 32'h0000_0400);
    idle();
    idle();
    #2 rst = 0;
    #1;
    chk("mid_stalled", 64'(stalled_o), 0);
    chk("mid_flush", 64'(flush_o), 0);
    chk("mid_pc_sel", 64'(pc_sel_o), 0);
    chk("mid_new_pc", 64'(new_pc_o), 0);
    chk("mid_cnt", 64'(stall_cnt_o), 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    drv(0, 0, 0, 0, 1, 32'h0000_0abc, 0, 0);
    repeat (TO) drv(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    chk("to_sticky", 64'(stall_timeout_o), 1);
    for (int k = 0; k < 500; k++)
      drv($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 3, $urandom,
          $urandom_range(0, 9) < 1, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
